// File: rtl/amp_power_sequencer_if.sv
// Status and control bundle between the S/PDIF side of the top level and the amplifier
// power sequencer.
interface amp_power_sequencer_if;
    logic       audio_locked;
    logic       mute_req;
    logic       force_off;
    logic       amp_fault_n;
    logic       nenable_out;
    logic       nmute_out;
    logic [2:0] state_o;

    modport master (
        output audio_locked,
        output mute_req,
        output force_off,
        output amp_fault_n,
        input  nenable_out,
        input  nmute_out,
        input  state_o
    );

    modport slave (
        input  audio_locked,
        input  mute_req,
        input  force_off,
        input  amp_fault_n,
        output nenable_out,
        output nmute_out,
        output state_o
    );
endinterface

// File: rtl/amp_power_sequencer.sv
// Click-free amplifier enable/mute sequencer: enable -> settle -> unmute, mute -> ramp -> disable.
// Define AMP_FAULT_EN to act on amp_fault_n (FAULT state with retry timer).
module amp_power_sequencer #(
    parameter int unsigned LOCK_DEBOUNCE_CYC = 1024,
    parameter int unsigned ENABLE_SETTLE_CYC = 65536,
    parameter int unsigned MUTE_RAMP_CYC     = 32768,
    parameter int unsigned FAULT_RETRY_CYC   = 1048576,
    parameter int unsigned CNT_W             = 21
) (
    input logic                   clk_in,
    input logic                   resetb,
    amp_power_sequencer_if.slave  amp
);

    typedef enum logic [2:0] {
        StOff      = 3'd0,
        StEnable   = 3'd1,
        StPlay     = 3'd2,
        StHold     = 3'd3,
        StMuteDown = 3'd4,
        StFault    = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] LOCK_TERM   = CNT_W'(LOCK_DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_TERM = CNT_W'(ENABLE_SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] RAMP_TERM   = CNT_W'(MUTE_RAMP_CYC - 1);
    localparam logic [CNT_W-1:0] RETRY_TERM  = CNT_W'(FAULT_RETRY_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             nenable_q, nenable_d;
    logic             nmute_q, nmute_d;
    logic [CNT_W-1:0] term;
    logic             done;
    logic             shutdown;
    logic             fault_hit;

`ifdef AMP_FAULT_EN
    // Only an enabled amplifier can report a meaningful fault.
    assign fault_hit = !amp.amp_fault_n && !nenable_q;
`else
    logic unused_amp_fault_n;
    assign unused_amp_fault_n = amp.amp_fault_n;
    assign fault_hit          = 1'b0;
`endif

    assign shutdown = amp.force_off || !amp.audio_locked;

    always_comb begin
        term = LOCK_TERM;
        case (state_q)
            StEnable:   term = SETTLE_TERM;
            StMuteDown: term = RAMP_TERM;
            StFault:    term = RETRY_TERM;
            default:    term = LOCK_TERM;
        endcase
    end

    assign done = (cnt_q == term);

    always_comb begin
        state_d = state_q;
        cnt_d   = done ? cnt_q : cnt_q + CNT_W'(1);

        case (state_q)
            StOff: begin
                if (shutdown) begin
                    cnt_d = '0;
                end else if (done) begin
                    state_d = StEnable;
                end
            end
            StEnable: begin
                if (shutdown) begin
                    state_d = StOff;
                end else if (done) begin
                    state_d = amp.mute_req ? StHold : StPlay;
                end
            end
            StPlay: begin
                if (shutdown) begin
                    state_d = StMuteDown;
                end else if (amp.mute_req) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (shutdown) begin
                    state_d = StMuteDown;
                end else if (!amp.mute_req) begin
                    state_d = StPlay;
                end
            end
            StMuteDown: begin
                if (done) begin
                    state_d = StOff;
                end
            end
`ifdef AMP_FAULT_EN
            StFault: begin
                if (done) begin
                    if (!amp.amp_fault_n) begin
                        cnt_d = '0;
                    end else begin
                        state_d = StOff;
                    end
                end
            end
`endif
            default: state_d = StOff;
        endcase

        if (fault_hit) begin
            state_d = StFault;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        nenable_d = !(state_d inside {StEnable, StPlay, StHold, StMuteDown});
        nmute_d   = (state_d == StPlay);
    end

    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            state_q   <= StOff;
            cnt_q     <= '0;
            nenable_q <= 1'b1;
            nmute_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nenable_q <= nenable_d;
            nmute_q   <= nmute_d;
        end
    end

    assign amp.nenable_out = nenable_q;
    assign amp.nmute_out   = nmute_q;
    assign amp.state_o     = state_q;

endmodule

// File: tb/tb_amp_power_sequencer.sv
// Directed bench for amp_power_sequencer with short timer parameters (4/8/6/5).
module tb_amp_power_sequencer;

    logic clk_in = 1'b0;
    logic resetb = 1'b1;
    int   n_cmp  = 0;
    int   n_err  = 0;

    amp_power_sequencer_if bus ();

    amp_power_sequencer #(
        .LOCK_DEBOUNCE_CYC (4),
        .ENABLE_SETTLE_CYC (8),
        .MUTE_RAMP_CYC     (6),
        .FAULT_RETRY_CYC   (5),
        .CNT_W             (21)
    ) dut (
        .clk_in (clk_in),
        .resetb (resetb),
        .amp    (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    // Advance one rising edge and settle just after it.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic reach_play();
        bus.audio_locked = 1'b1;
        bus.mute_req     = 1'b0;
        bus.force_off    = 1'b0;
        step(12);
    endtask

    task automatic test_reset();
        #2 resetb = 1'b0;
        #1;
        n_cmp++;
        if (bus.nenable_out !== 1'b1 || bus.nmute_out !== 1'b0 || bus.state_o !== 3'd0) begin
            n_err++;
            $display("FAIL reset_values: got nen=%b nmute=%b state=%0d, want 1 0 0",
                     bus.nenable_out, bus.nmute_out, bus.state_o);
        end
        step(2);
        resetb = 1'b1;
        step(2);
        n_cmp++;
        if (bus.state_o !== 3'd0 || bus.nenable_out !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_idle: got state=%0d nen=%b, want 0 1",
                     bus.state_o, bus.nenable_out);
        end
    endtask

    task automatic test_lock_up();
        bus.audio_locked = 1'b1;
        step(3);
        n_cmp++;
        if (bus.state_o !== 3'd0 || bus.nenable_out !== 1'b1) begin
            n_err++;
            $display("FAIL lock_edge3: got state=%0d nen=%b, want 0 1",
                     bus.state_o, bus.nenable_out);
        end
        step(1);
        n_cmp++;
        if (bus.state_o !== 3'd1 || bus.nenable_out !== 1'b0 || bus.nmute_out !== 1'b0) begin
            n_err++;
            $display("FAIL lock_edge4_enable: got state=%0d nen=%b nmute=%b, want 1 0 0",
                     bus.state_o, bus.nenable_out, bus.nmute_out);
        end
        step(7);
        n_cmp++;
        if (bus.state_o !== 3'd1 || bus.nmute_out !== 1'b0) begin
            n_err++;
            $display("FAIL settle_edge7: got state=%0d nmute=%b, want 1 0",
                     bus.state_o, bus.nmute_out);
        end
        step(1);
        n_cmp++;
        if (bus.state_o !== 3'd2 || bus.nmute_out !== 1'b1 || bus.nenable_out !== 1'b0) begin
            n_err++;
            $display("FAIL settle_edge8_play: got state=%0d nen=%b nmute=%b, want 2 0 1",
                     bus.state_o, bus.nenable_out, bus.nmute_out);
        end
    endtask

    task automatic test_async_reset();
        #3 resetb = 1'b0;
        #1;
        n_cmp++;
        if (bus.nenable_out !== 1'b1 || bus.nmute_out !== 1'b0 || bus.state_o !== 3'd0) begin
            n_err++;
            $display("FAIL async_reset_midplay: got nen=%b nmute=%b state=%0d, want 1 0 0",
                     bus.nenable_out, bus.nmute_out, bus.state_o);
        end
        bus.audio_locked = 1'b0;
        step(2);
        resetb = 1'b1;
        step(3);
        n_cmp++;
        if (bus.nenable_out !== 1'b1 || bus.nmute_out !== 1'b0 || bus.state_o !== 3'd0) begin
            n_err++;
            $display("FAIL async_reset_hold: got nen=%b nmute=%b state=%0d, want 1 0 0",
                     bus.nenable_out, bus.nmute_out, bus.state_o);
        end
    endtask

    task automatic test_debounce_glitch();
        logic [6:0] pattern;
        pattern = 7'b1110111;
        for (int i = 6; i >= 0; i--) begin
            bus.audio_locked = pattern[i];
            step(1);
            n_cmp++;
            if (bus.nenable_out !== 1'b1 || bus.state_o !== 3'd0) begin
                n_err++;
                $display("FAIL debounce_glitch[%0d]: got nen=%b state=%0d, want 1 0",
                         6 - i, bus.nenable_out, bus.state_o);
            end
        end
        bus.audio_locked = 1'b0;
        step(1);
    endtask

    task automatic test_lock_loss();
        reach_play();
        n_cmp++;
        if (bus.state_o !== 3'd2) begin
            n_err++;
            $display("FAIL lockloss_in_play: got state=%0d, want 2", bus.state_o);
        end
        bus.audio_locked = 1'b0;
        step(1);
        n_cmp++;
        if (bus.state_o !== 3'd4 || bus.nmute_out !== 1'b0 || bus.nenable_out !== 1'b0) begin
            n_err++;
            $display("FAIL lockloss_mutedown: got state=%0d nen=%b nmute=%b, want 4 0 0",
                     bus.state_o, bus.nenable_out, bus.nmute_out);
        end
        bus.audio_locked = 1'b1;  // relock must not shorten the ramp
        step(5);
        n_cmp++;
        if (bus.state_o !== 3'd4 || bus.nenable_out !== 1'b0) begin
            n_err++;
            $display("FAIL ramp_edge5: got state=%0d nen=%b, want 4 0",
                     bus.state_o, bus.nenable_out);
        end
        step(1);
        n_cmp++;
        if (bus.state_o !== 3'd0 || bus.nenable_out !== 1'b1) begin
            n_err++;
            $display("FAIL ramp_edge6_off: got state=%0d nen=%b, want 0 1",
                     bus.state_o, bus.nenable_out);
        end
        bus.audio_locked = 1'b0;
        step(1);
    endtask

    task automatic test_mute_hold();
        bus.audio_locked = 1'b1;
        step(4);
        n_cmp++;
        if (bus.state_o !== 3'd1) begin
            n_err++;
            $display("FAIL hold_enable: got state=%0d, want 1", bus.state_o);
        end
        bus.mute_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            n_cmp++;
            if (bus.nmute_out !== 1'b0) begin
                n_err++;
                $display("FAIL hold_muted[%0d]: got nmute=%b, want 0", i, bus.nmute_out);
            end
        end
        n_cmp++;
        if (bus.state_o !== 3'd3) begin
            n_err++;
            $display("FAIL hold_state: got state=%0d, want 3", bus.state_o);
        end
        bus.mute_req = 1'b0;
        step(1);
        n_cmp++;
        if (bus.state_o !== 3'd2 || bus.nmute_out !== 1'b1) begin
            n_err++;
            $display("FAIL unmute_play: got state=%0d nmute=%b, want 2 1",
                     bus.state_o, bus.nmute_out);
        end
        bus.force_off = 1'b1;
        step(1);
        n_cmp++;
        if (bus.state_o !== 3'd4 || bus.nmute_out !== 1'b0) begin
            n_err++;
            $display("FAIL force_off_mutedown: got state=%0d nmute=%b, want 4 0",
                     bus.state_o, bus.nmute_out);
        end
        step(6);
        n_cmp++;
        if (bus.state_o !== 3'd0 || bus.nenable_out !== 1'b1) begin
            n_err++;
            $display("FAIL force_off_off: got state=%0d nen=%b, want 0 1",
                     bus.state_o, bus.nenable_out);
        end
        step(5);
        n_cmp++;
        if (bus.state_o !== 3'd0) begin
            n_err++;
            $display("FAIL force_off_holds_off: got state=%0d, want 0", bus.state_o);
        end
        bus.force_off    = 1'b0;
        bus.audio_locked = 1'b0;
        step(1);
    endtask

    task automatic test_fault();
        reach_play();
        bus.amp_fault_n = 1'b0;
        step(1);
        bus.amp_fault_n = 1'b1;
`ifdef AMP_FAULT_EN
        n_cmp++;
        if (bus.state_o !== 3'd5 || bus.nenable_out !== 1'b1 || bus.nmute_out !== 1'b0) begin
            n_err++;
            $display("FAIL fault_entry: got state=%0d nen=%b nmute=%b, want 5 1 0",
                     bus.state_o, bus.nenable_out, bus.nmute_out);
        end
        step(4);
        n_cmp++;
        if (bus.state_o !== 3'd5) begin
            n_err++;
            $display("FAIL fault_hold: got state=%0d, want 5", bus.state_o);
        end
        step(1);
        n_cmp++;
        if (bus.state_o !== 3'd0) begin
            n_err++;
            $display("FAIL fault_exit: got state=%0d, want 0", bus.state_o);
        end
        step(3);
        n_cmp++;
        if (bus.state_o !== 3'd0) begin
            n_err++;
            $display("FAIL fault_debounce3: got state=%0d, want 0", bus.state_o);
        end
        step(1);
        n_cmp++;
        if (bus.state_o !== 3'd1) begin
            n_err++;
            $display("FAIL fault_debounce4: got state=%0d, want 1", bus.state_o);
        end
`else
        n_cmp++;
        if (bus.state_o !== 3'd2 || bus.nmute_out !== 1'b1 || bus.nenable_out !== 1'b0) begin
            n_err++;
            $display("FAIL fault_ignored: got state=%0d nen=%b nmute=%b, want 2 0 1",
                     bus.state_o, bus.nenable_out, bus.nmute_out);
        end
        step(5);
        n_cmp++;
        if (bus.state_o !== 3'd2) begin
            n_err++;
            $display("FAIL fault_ignored_later: got state=%0d, want 2", bus.state_o);
        end
`endif
    endtask

    initial begin
        bus.audio_locked = 1'b0;
        bus.mute_req     = 1'b0;
        bus.force_off    = 1'b0;
        bus.amp_fault_n  = 1'b1;
        test_reset();
        test_lock_up();
        test_async_reset();
        test_debounce_glitch();
        test_lock_loss();
        test_mute_hold();
        test_fault();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
